axilite_master_traffic_gen: RTL and testbench

AXILITE_MASTER_TRAFFIC_GEN -- requirements
Module: axilite_master_traffic_gen

---
 rtl/axilite_master_traffic_gen.sv | 196 +++++++++++++++++++
 tb/tb_axilite_master_traffic_gen.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axilite_master_traffic_gen.sv
// axilite_master_traffic_gen
// Self-contained AXI4-Lite master traffic generator. One run writes
// NUM_XFERS words to BASE_ADDR + i*ADDR_STRIDE and then reads the same
// addresses back. It compares each read against the write pattern and
// tallies errors. At most one transaction is outstanding at a time.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 run request (sampled only when idle or done)
//   busy                  a run is in progress
//   done                  run complete, held until the next start
//   pass                  done with zero errors
//   err_count             saturating count of bad responses / data
//   m_axi_aw*/w*/b*       AXI-Lite write address, data and response channels
//   m_axi_ar*/r*          AXI-Lite read address and data channels
module axilite_master_traffic_gen #(
    parameter int                    ADDR_WIDTH  = 64,
    parameter int                    DATA_WIDTH  = 64,
    parameter int                    NUM_XFERS   = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter logic [ADDR_WIDTH-1:0] ADDR_STRIDE = ADDR_WIDTH'(8),
    parameter logic [31:0]           SEED        = 32'hA5A5_0000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [15:0]             err_count,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    localparam int            IW       = $clog2(NUM_XFERS + 1);
    localparam int            NREP     = DATA_WIDTH / 32;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_XFERS - 1);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, DONE} state_t;

    state_t                  state, state_nxt;
    logic [IW-1:0]           idx;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [31:0]             pat;
    logic                    aw_done, w_done;
    logic [15:0]             errs;
    logic                    aw_fire, w_fire, b_fire, ar_fire, r_fire;
    logic                    is_last, rd_bad;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Handshakes are derived from state rather than from the valid/ready
    // outputs, so the output logic below never feeds back on itself.
    assign aw_fire = (state == WR_REQ)  && !aw_done && m_axi_awready;
    assign w_fire  = (state == WR_REQ)  && !w_done  && m_axi_wready;
    assign b_fire  = (state == WR_RESP) && m_axi_bvalid;
    assign ar_fire = (state == RD_REQ)  && m_axi_arready;
    assign r_fire  = (state == RD_DATA) && m_axi_rvalid;
    assign is_last = (idx == LAST_IDX);
    assign rd_bad  = (m_axi_rresp != 2'b00) || (m_axi_rdata != {NREP{pat}});

    // The address and pattern registers serve both the write and read phases.
    // They hold steady while a request is pending and reset to zero.
    assign m_axi_awaddr = addr;
    assign m_axi_araddr = addr;
    assign m_axi_wdata  = {NREP{pat}};
    assign m_axi_wstrb  = '1;
    assign err_count    = errs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        busy          = 1'b0;
        done          = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = WR_REQ;
            end
            WR_REQ: begin
                busy          = 1'b1;
                // AW and W complete independently; each valid drops once its own beat is accepted.
                m_axi_awvalid = !aw_done;
                m_axi_wvalid  = !w_done;
                if ((aw_done || aw_fire) && (w_done || w_fire)) state_nxt = WR_RESP;
            end
            WR_RESP: begin
                busy         = 1'b1;
                m_axi_bready = 1'b1;
                if (b_fire) state_nxt = is_last ? RD_REQ : WR_REQ;
            end
            RD_REQ: begin
                busy          = 1'b1;
                m_axi_arvalid = 1'b1;
                if (ar_fire) state_nxt = RD_DATA;
            end
            RD_DATA: begin
                busy         = 1'b1;
                m_axi_rready = 1'b1;
                if (r_fire) state_nxt = is_last ? DONE : RD_REQ;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_nxt = WR_REQ;
            end
            default: state_nxt = IDLE;
        endcase
        pass = done && (errs == 16'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            addr    <= '0;
            pat     <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            errs    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        idx     <= '0;
                        addr    <= BASE_ADDR;
                        pat     <= SEED;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        errs    <= '0;
                    end
                end
                WR_REQ: begin
                    if (aw_fire) aw_done <= 1'b1;
                    if (w_fire)  w_done  <= 1'b1;
                end
                WR_RESP: begin
                    if (b_fire) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        if (m_axi_bresp != 2'b00) errs <= sat_inc(errs);
                        // The last write rewinds index, address and pattern for the read pass.
                        if (is_last) begin
                            idx  <= '0;
                            addr <= BASE_ADDR;
                            pat  <= SEED;
                        end else begin
                            idx  <= idx + IW'(1);
                            addr <= addr + ADDR_STRIDE;
                            pat  <= pat + 32'd1;
                        end
                    end
                end
                RD_DATA: begin
                    if (r_fire) begin
                        // A bad response and bad data on the same beat count as one error.
                        if (rd_bad) errs <= sat_inc(errs);
                        if (!is_last) begin
                            idx  <= idx + IW'(1);
                            addr <= addr + ADDR_STRIDE;
                            pat  <= pat + 32'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axilite_master_traffic_gen.sv
module tb_axilite_master_traffic_gen;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_addr(input int k);
        return 64'(k % 16) * 64'd8;
    endfunction

    function automatic logic [63:0] exp_data(input int k);
        logic [31:0] p;
        p = 32'hA5A5_0000 + 32'(k % 16);
        return {p, p};
    endfunction

    // ---------------- DUT 0: default parameters ----------------
    logic        start = 1'b0;
    logic        busy, done, pass;
    logic [15:0] err_count;
    logic [63:0] awaddr, wdata, araddr;
    logic [7:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready = 1'b0, wready = 1'b0, arready = 1'b0;
    logic        bvalid = 1'b0, rvalid = 1'b0;
    logic [1:0]  bresp = 2'b00, rresp = 2'b00;
    logic [63:0] rdata = '0;

    axilite_master_traffic_gen u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .pass(pass), .err_count(err_count),
        .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid),
        .m_axi_wready(wready), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
        .m_axi_bready(bready), .m_axi_araddr(araddr), .m_axi_arvalid(arvalid),
        .m_axi_arready(arready), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    // ---------------- DUT 1: single transfer at the top of the address space ----------------
    logic        start_1 = 1'b0;
    logic        busy_1, done_1, pass_1;
    logic [15:0] err_count_1;
    logic [63:0] awaddr_1, wdata_1, araddr_1;
    logic [7:0]  wstrb_1;
    logic        awvalid_1, wvalid_1, bready_1, arvalid_1, rready_1;
    logic        awready_1, wready_1, arready_1, bvalid_1, rvalid_1;
    logic [1:0]  bresp_1, rresp_1;
    logic [63:0] rdata_1;

    assign awready_1 = 1'b1;
    assign wready_1  = 1'b1;
    assign arready_1 = 1'b1;
    assign bvalid_1  = 1'b1;
    assign rvalid_1  = 1'b1;
    assign bresp_1   = 2'b00;
    assign rresp_1   = 2'b00;
    assign rdata_1   = 64'hA5A5_0000_A5A5_0000;

    axilite_master_traffic_gen #(
        .NUM_XFERS(1), .BASE_ADDR(64'hFFFF_FFFF_FFFF_FFF8), .ADDR_STRIDE(64'd8)
    ) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_1), .busy(busy_1), .done(done_1),
        .pass(pass_1), .err_count(err_count_1),
        .m_axi_awaddr(awaddr_1), .m_axi_awvalid(awvalid_1), .m_axi_awready(awready_1),
        .m_axi_wdata(wdata_1), .m_axi_wstrb(wstrb_1), .m_axi_wvalid(wvalid_1),
        .m_axi_wready(wready_1), .m_axi_bresp(bresp_1), .m_axi_bvalid(bvalid_1),
        .m_axi_bready(bready_1), .m_axi_araddr(araddr_1), .m_axi_arvalid(arvalid_1),
        .m_axi_arready(arready_1), .m_axi_rdata(rdata_1), .m_axi_rresp(rresp_1),
        .m_axi_rvalid(rvalid_1), .m_axi_rready(rready_1)
    );

    // ---------------- slave model and monitor for DUT 0 ----------------
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    int aw_base = 0, w_base = 0, b_base = 0, ar_base = 0, r_base = 0;
    bit stray = 1'b0, stall_on = 1'b0;
    int err_b = -1, bad_r = -1;
    int age = 0;

    always @(posedge clk) begin
        logic [31:0] rp;
        #1;
        age     = (w_cnt > aw_cnt) ? age + 1 : 0;
        awready = !stall_on || ((aw_cnt - aw_base) != 0) || (age >= 3);
        wready  = 1'b1;
        arready = 1'b1;
        bvalid  = stray || ((aw_cnt > b_cnt) && (w_cnt > b_cnt));
        bresp   = (stray || (((b_cnt - b_base) % 16) == err_b)) ? 2'b10 : 2'b00;
        rvalid  = stray || (ar_cnt > r_cnt);
        rresp   = stray ? 2'b10 : 2'b00;
        rp      = 32'hA5A5_0000 + 32'((r_cnt - r_base) % 16);
        rdata   = {rp, rp} ^ ((((r_cnt - r_base) % 16) == bad_r) ? 64'd1 : 64'd0);
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (awvalid && (w_cnt > aw_cnt)) begin
                check("wvalid_drop", {63'd0, wvalid}, 64'd0);
                check("awaddr_hold", awaddr, exp_addr(aw_cnt - aw_base));
            end
            if (awvalid && awready) begin
                check("awaddr", awaddr, exp_addr(aw_cnt - aw_base));
                aw_cnt++;
            end
            if (wvalid && wready) begin
                check("wdata", wdata, exp_data(w_cnt - w_base));
                check("wstrb", {56'd0, wstrb}, 64'hFF);
                w_cnt++;
            end
            if (bvalid && bready) b_cnt++;
            if (arvalid && arready) begin
                check("araddr", araddr, exp_addr(ar_cnt - ar_base));
                ar_cnt++;
            end
            if (rvalid && rready) r_cnt++;
        end
    end

    // ---------------- monitor for DUT 1 ----------------
    int aw1_cnt = 0, w1_cnt = 0, b1_cnt = 0, ar1_cnt = 0, r1_cnt = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (awvalid_1 && awready_1) begin
                check("u1_awaddr", awaddr_1, 64'hFFFF_FFFF_FFFF_FFF8);
                aw1_cnt++;
            end
            if (wvalid_1 && wready_1) begin
                check("u1_wdata", wdata_1, 64'hA5A5_0000_A5A5_0000);
                check("u1_wstrb", {56'd0, wstrb_1}, 64'hFF);
                w1_cnt++;
            end
            if (bvalid_1 && bready_1) b1_cnt++;
            if (arvalid_1 && arready_1) begin
                check("u1_araddr", araddr_1, 64'hFFFF_FFFF_FFFF_FFF8);
                ar1_cnt++;
            end
            if (rvalid_1 && rready_1) r1_cnt++;
        end
    end

    // ---------------- helpers ----------------
    task automatic mark();
        aw_base = aw_cnt; w_base = w_cnt; b_base = b_cnt; ar_base = ar_cnt; r_base = r_cnt;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ctl"}, {56'd0, busy, done, pass, awvalid, wvalid, bready, arvalid, rready}, 64'd0);
        check({tag, "_err"}, {48'd0, err_count}, 64'd0);
        check({tag, "_awaddr"}, awaddr, 64'd0);
        check({tag, "_araddr"}, araddr, 64'd0);
        check({tag, "_wdata"}, wdata, 64'd0);
    endtask

    task automatic check_counts(input string tag, input int n);
        check({tag, "_aw"}, 64'(aw_cnt - aw_base), 64'(n));
        check({tag, "_w"},  64'(w_cnt - w_base),   64'(n));
        check({tag, "_b"},  64'(b_cnt - b_base),   64'(n));
        check({tag, "_ar"}, 64'(ar_cnt - ar_base), 64'(n));
        check({tag, "_r"},  64'(r_cnt - r_base),   64'(n));
    endtask

    // Cycles are counted from the edge that samples start to the first
    // negedge at which done is seen.
    task automatic run(input bit hold, input int pulse_at, output int n);
        @(negedge clk);
        start = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
            start = hold || (n == pulse_at);
        end while (!done && n < 400);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check_reset("reset");
        check("reset_u1", {61'd0, busy_1, done_1, pass_1}, 64'd0);
        rst_n = 1'b1;

        // Stray responses while idle are not accepted.
        stray = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            check("stray_ready", {62'd0, bready, rready}, 64'd0);
            check("stray_busy", {63'd0, busy}, 64'd0);
        end
        stray = 1'b0;
        repeat (2) @(negedge clk);

        // Zero-wait run with an ignored start pulse mid-run.
        mark();
        run(1'b0, 10, n);
        check("run1_cycles", 64'(n), 64'd65);
        check_counts("run1", 16);
        check("run1_flags", {61'd0, busy, done, pass}, 64'b011);
        check("run1_err", {48'd0, err_count}, 64'd0);
        repeat (3) @(negedge clk);
        check("run1_sticky", {62'd0, done, pass}, 64'b11);

        // AW accepted three cycles after W on the first write.
        stall_on = 1'b1;
        mark();
        run(1'b0, 0, n);
        stall_on = 1'b0;
        check("stall_cycles", 64'(n), 64'd68);
        check_counts("stall", 16);
        check("stall_pass", {62'd0, done, pass}, 64'b11);

        // SLVERR on B[2], corrupted R[5].
        err_b = 2;
        bad_r = 5;
        mark();
        run(1'b0, 0, n);
        err_b = -1;
        bad_r = -1;
        check("errs_count", {48'd0, err_count}, 64'd2);
        check("errs_flags", {61'd0, busy, done, pass}, 64'b010);

        // Reset asserted while in RD_DATA for index 7.
        err_b = 2;
        mark();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(rready && (r_cnt - r_base) == 8) && n < 200);
        check("midrst_reached", {63'd0, rready}, 64'd1);
        check("midrst_err_before", {48'd0, err_count}, 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset("midrst");
        err_b = -1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            #1;
            check("postrst_quiet", {60'd0, awvalid, wvalid, arvalid, busy}, 64'd0);
        end
        mark();
        run(1'b0, 0, n);
        check_counts("fresh", 16);
        check("fresh_err", {48'd0, err_count}, 64'd0);
        check("fresh_pass", {62'd0, done, pass}, 64'b11);

        // start held for the whole run: one run, then a restart sampled in DONE.
        mark();
        run(1'b1, 0, n);
        check("hold_one_run", 64'(aw_cnt - aw_base), 64'd16);
        check("hold_done", {62'd0, busy, done}, 64'b01);
        @(negedge clk);
        #1;
        start = 1'b0;
        check("hold_restart", {62'd0, busy, done}, 64'b10);
        run(1'b0, 0, n);
        check_counts("hold_two_runs", 32);
        check("hold_pass", {62'd0, done, pass}, 64'b11);

        // Single-transfer instance wrapping at the top of the address space.
        @(negedge clk);
        start_1 = 1'b1;
        @(negedge clk);
        start_1 = 1'b0;
        n = 0;
        while (!done_1 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("u1_flags", {61'd0, busy_1, done_1, pass_1}, 64'b011);
        check("u1_err", {48'd0, err_count_1}, 64'd0);
        repeat (3) @(negedge clk);
        check("u1_counts", {aw1_cnt[7:0], w1_cnt[7:0], b1_cnt[7:0], ar1_cnt[7:0], r1_cnt[7:0]},
              64'h01_01_01_01_01);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
